// File: rtl/alu4_acc_ctrl.sv
// Command controller and accumulator wrapped around a combinational 4-bit ALU.
// EXEC runs rpt+1 ISSUE/CAPTURE iterations; LOAD writes the accumulator directly.
module alu4_acc_ctrl (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_load,
    input  logic [2:0] cmd_op,
    input  logic [3:0] cmd_operand,
    input  logic [1:0] cmd_rpt,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    output logic [2:0] alu_op,
    input  logic [3:0] alu_result,
    input  logic       alu_c,
    input  logic       alu_n,
    input  logic       alu_z,
    input  logic       alu_v,
    output logic [3:0] acc,
    output logic [3:0] flags,
    output logic       sticky_v,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t     state_q;
    logic [3:0] acc_q;
    logic [3:0] flags_q;
    logic       sticky_q;
    logic [3:0] alu_a_q;
    logic [3:0] alu_b_q;
    logic [2:0] alu_op_q;
    logic [1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            acc_q    <= 4'd0;
            flags_q  <= 4'd0;
            sticky_q <= 1'b0;
            alu_a_q  <= 4'd0;
            alu_b_q  <= 4'd0;
            alu_op_q <= 3'd0;
            cnt_q    <= 2'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cmd_valid) begin
                        if (cmd_load) begin
                            acc_q   <= cmd_operand;
                            state_q <= DONE;
                        end else begin
                            alu_a_q  <= acc_q;
                            alu_b_q  <= cmd_operand;
                            alu_op_q <= cmd_op;
                            cnt_q    <= cmd_rpt;
                            sticky_q <= 1'b0;
                            state_q  <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    state_q <= CAPTURE;
                end
                CAPTURE: begin
                    // Feed the result back as the next A operand so repeats chain.
                    acc_q    <= alu_result;
                    flags_q  <= {alu_c, alu_n, alu_z, alu_v};
                    sticky_q <= sticky_q | alu_v;
                    alu_a_q  <= alu_result;
                    if (cnt_q == 2'd0) begin
                        state_q <= DONE;
                    end else begin
                        cnt_q   <= cnt_q - 2'd1;
                        state_q <= ISSUE;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign cmd_ready = (state_q == IDLE);
    assign busy      = (state_q == ISSUE) || (state_q == CAPTURE);
    assign done      = (state_q == DONE);
    assign acc       = acc_q;
    assign flags     = flags_q;
    assign sticky_v  = sticky_q;
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_op    = alu_op_q;

endmodule

// File: tb/tb_alu4_acc_ctrl.sv
// Scoreboarded bench for alu4_acc_ctrl with a behavioural add-only ALU model.
module tb_alu4_acc_ctrl;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_load;
    logic [2:0] cmd_op;
    logic [3:0] cmd_operand;
    logic [1:0] cmd_rpt;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [2:0] alu_op;
    logic [3:0] alu_result;
    logic       alu_c, alu_n, alu_z, alu_v;
    logic [3:0] acc;
    logic [3:0] flags;
    logic       sticky_v;
    logic       busy;
    logic       done;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [3:0] acc;
        logic [3:0] flags;
        logic       sticky;
    } exp_t;

    exp_t       sb[$];
    logic [3:0] a_seq [0:3];

    always #5 clk = ~clk;

    alu4_acc_ctrl dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_load    (cmd_load),
        .cmd_op      (cmd_op),
        .cmd_operand (cmd_operand),
        .cmd_rpt     (cmd_rpt),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_op      (alu_op),
        .alu_result  (alu_result),
        .alu_c       (alu_c),
        .alu_n       (alu_n),
        .alu_z       (alu_z),
        .alu_v       (alu_v),
        .acc         (acc),
        .flags       (flags),
        .sticky_v    (sticky_v),
        .busy        (busy),
        .done        (done)
    );

    // Behavioural ALU: only op 010 (add) is modelled, other ops yield zero.
    logic [4:0] sum5;
    always_comb begin
        sum5       = {1'b0, alu_a} + {1'b0, alu_b};
        alu_result = 4'd0;
        alu_c      = 1'b0;
        alu_v      = 1'b0;
        if (alu_op == 3'b010) begin
            alu_result = sum5[3:0];
            alu_c      = sum5[4];
            alu_v      = (alu_a[3] == alu_b[3]) && (sum5[3] != alu_a[3]);
        end
        alu_n = alu_result[3];
        alu_z = (alu_result == 4'd0);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse is matched against the oldest expected completion.
    always @(negedge clk) begin
        if (reset_n === 1'b1 && done === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("sb_acc", {28'd0, acc}, {28'd0, e.acc});
                chk("sb_flags", {28'd0, flags}, {28'd0, e.flags});
                chk("sb_sticky", {31'd0, sticky_v}, {31'd0, e.sticky});
            end
        end
    end

    task automatic send_cmd(input logic ld, input logic [2:0] op, input logic [3:0] opnd,
                            input logic [1:0] rpt);
        @(negedge clk);
        chk("ready_before_accept", {31'd0, cmd_ready}, 32'd1);
        cmd_valid   = 1'b1;
        cmd_load    = ld;
        cmd_op      = op;
        cmd_operand = opnd;
        cmd_rpt     = rpt;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    // Samples cycles first_n..exp_n+1 after the accept edge; done must sit exactly at exp_n.
    task automatic wait_done(input int first_n, input int exp_n, input int exp_busy,
                             input string name);
        int done_at = 0;
        int pulses  = 0;
        int busy_cnt = 0;
        for (int n = first_n; n <= exp_n + 1; n++) begin
            @(negedge clk);
            if (busy === 1'b1) busy_cnt++;
            if (done === 1'b1) begin
                pulses++;
                if (done_at == 0) done_at = n;
            end
            if ((n % 2 == 1) && ((n - 1) / 2 < 4)) a_seq[(n - 1) / 2] = alu_a;
        end
        chk({name, "_done_cycle"}, done_at, exp_n);
        chk({name, "_done_pulses"}, pulses, 1);
        chk({name, "_busy_cycles"}, busy_cnt, exp_busy);
        chk({name, "_ready_after"}, {31'd0, cmd_ready}, 32'd1);
    endtask

    task automatic do_load(input logic [3:0] v, input logic [3:0] fl, input logic st,
                           input string name);
        sb.push_back('{acc: v, flags: fl, sticky: st});
        send_cmd(1'b1, 3'b000, v, 2'd0);
        wait_done(1, 1, 0, name);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n     = 1'b0;
        cmd_valid   = 1'b1;
        cmd_load    = 1'b1;
        cmd_op      = 3'b010;
        cmd_operand = 4'hF;
        cmd_rpt     = 2'd3;

        // Reset held for two edges with a command pending.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_acc", {28'd0, acc}, 32'd0);
        chk("rst_flags", {28'd0, flags}, 32'd0);
        chk("rst_alu_a", {28'd0, alu_a}, 32'd0);
        chk("rst_alu_b", {28'd0, alu_b}, 32'd0);
        chk("rst_alu_op", {29'd0, alu_op}, 32'd0);
        chk("rst_sticky", {31'd0, sticky_v}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        reset_n   = 1'b1;
        cmd_valid = 1'b0;
        @(negedge clk);
        chk("rst_ready", {31'd0, cmd_ready}, 32'd1);

        // LOAD 5: acc updates on the accept edge, flags untouched.
        sb.push_back('{acc: 4'h5, flags: 4'h0, sticky: 1'b0});
        send_cmd(1'b1, 3'b000, 4'h5, 2'd0);
        wait_done(1, 1, 0, "load5");

        // LOAD 3 then EXEC add 4, single pass.
        do_load(4'h3, 4'h0, 1'b0, "load3a");
        sb.push_back('{acc: 4'h7, flags: 4'b0000, sticky: 1'b0});
        send_cmd(1'b0, 3'b010, 4'h4, 2'd0);
        @(negedge clk);
        chk("exec0_alu_a", {28'd0, alu_a}, 32'd3);
        chk("exec0_alu_b", {28'd0, alu_b}, 32'd4);
        chk("exec0_alu_op", {29'd0, alu_op}, 32'd2);
        wait_done(2, 3, 1, "exec0");

        // LOAD 3 then EXEC add 4 four times: 3,7,11,15 -> 3 with carry.
        do_load(4'h3, 4'h0, 1'b0, "load3b");
        sb.push_back('{acc: 4'h3, flags: 4'b1000, sticky: 1'b1});
        send_cmd(1'b0, 3'b010, 4'h4, 2'd3);
        wait_done(1, 9, 8, "exec3");
        chk("exec3_a0", {28'd0, a_seq[0]}, 32'd3);
        chk("exec3_a1", {28'd0, a_seq[1]}, 32'd7);
        chk("exec3_a2", {28'd0, a_seq[2]}, 32'd11);
        chk("exec3_a3", {28'd0, a_seq[3]}, 32'd15);

        // LOAD keeps the flags and sticky bit left by the previous EXEC.
        do_load(4'h3, 4'b1000, 1'b1, "load3c");
        sb.push_back('{acc: 4'h7, flags: 4'b0000, sticky: 1'b0});
        send_cmd(1'b0, 3'b010, 4'h4, 2'd0);
        @(negedge clk);
        chk("reject_ready", {31'd0, cmd_ready}, 32'd0);
        cmd_valid   = 1'b1;
        cmd_load    = 1'b1;
        cmd_operand = 4'h9;
        wait_done(2, 3, 1, "reject");
        cmd_valid = 1'b0;
        @(negedge clk);
        chk("reject_acc", {28'd0, acc}, 32'd7);
        chk("reject_no_done", {31'd0, done}, 32'd0);

        // Reset during the first CAPTURE of an rpt=2 EXEC: no completion is expected.
        send_cmd(1'b0, 3'b010, 4'h4, 2'd2);
        @(negedge clk);
        @(negedge clk);
        chk("mid_busy", {31'd0, busy}, 32'd1);
        reset_n = 1'b0;
        @(negedge clk);
        chk("mid_acc", {28'd0, acc}, 32'd0);
        chk("mid_flags", {28'd0, flags}, 32'd0);
        chk("mid_sticky", {31'd0, sticky_v}, 32'd0);
        chk("mid_alu_a", {28'd0, alu_a}, 32'd0);
        chk("mid_ready", {31'd0, cmd_ready}, 32'd1);
        chk("mid_busy_after", {31'd0, busy}, 32'd0);
        reset_n = 1'b1;
        repeat (6) @(negedge clk);

        do_load(4'hA, 4'h0, 1'b0, "loadA");
        repeat (3) @(negedge clk);
        chk("sb_empty", sb.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
